// File: rtl/reg_write_sequencer_pkg.sv
// Shared definitions for the latch-strobed register write sequencer.
// State encodings and the data bus width used by every file in this block.
package reg_write_sequencer_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    STROBE = ST_STROBE,
    HOLD   = ST_HOLD
  } state_t;

endpackage

// File: rtl/reg_write_sequencer_if.sv
// Request handshake plus register-bus signals of the write sequencer.
// The sequencer is the slave; the control unit is the master.
interface reg_write_sequencer_if import reg_write_sequencer_pkg::*; #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int CNT_W    = 3
) ();

  logic                req_valid;
  logic                req_ready;
  logic [SEL_W-1:0]    req_sel;
  logic [DATA_W-1:0]   req_data;
  logic                err_clr;
  logic [DATA_W-1:0]   reg_data;
  logic [NUM_REGS-1:0] reg_latch;
  logic                busy;
  logic [CNT_W-1:0]    pending;
  logic                err_sel;

  modport master (
    output req_valid, req_sel, req_data, err_clr,
    input  req_ready, reg_data, reg_latch, busy, pending, err_sel
  );

  modport slave (
    input  req_valid, req_sel, req_data, err_clr,
    output req_ready, reg_data, reg_latch, busy, pending, err_sel
  );

endinterface

// File: rtl/reg_write_sequencer_fifo.sv
// Synchronous request FIFO with synchronous active-low reset.
// Head is always the oldest entry; pointers wrap naturally (power-of-2 depth).
module reg_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));

endmodule

// File: rtl/reg_write_sequencer.sv
// Write sequencer: queues register writes and plays each out as
// data setup, one-cycle latch strobe, then data hold.
module reg_write_sequencer import reg_write_sequencer_pkg::*; #(
  parameter int NUM_REGS   = 8,
  parameter int SEL_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_write_sequencer_if.slave bus
);

  localparam int             ENTRY_W   = SEL_W + DATA_W;
  localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W + 1)'(NUM_REGS);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NUM_REGS-1:0] latch_q, latch_d;
  logic                err_q, err_d;

  logic               sel_ok_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic [ENTRY_W-1:0] head_s;
  logic [CNT_W-1:0]   count_s;
  logic               full_s;
  logic               empty_s;

  assign sel_ok_s      = ({1'b0, bus.req_sel} < NUM_REGS_W);
  assign bus.req_ready = rst_n && !full_s;
  assign accept_s      = bus.req_valid && bus.req_ready;
  assign push_s        = accept_s && sel_ok_s;

  reg_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({bus.req_sel, bus.req_data}),
    .head_o  (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    latch_d = '0;
    pop_s   = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        // No bypass: only entries already counted at cycle start are popped.
        if (!empty_s) begin
          pop_s   = 1'b1;
          data_d  = head_s[DATA_W-1:0];
          sel_d   = head_s[ENTRY_W-1:DATA_W];
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = STROBE;
        for (int i = 0; i < NUM_REGS; i++) begin
          latch_d[i] = (sel_q == SEL_W'(i));
        end
      end
      STROBE:  state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  // Set wins over clear when an invalid select arrives with err_clr.
  always_comb begin
    if (accept_s && !sel_ok_s) begin
      err_d = 1'b1;
    end else if (bus.err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      sel_q   <= '0;
      latch_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      latch_q <= latch_d;
      err_q   <= err_d;
    end
  end

  assign bus.reg_data  = data_q;
  assign bus.reg_latch = latch_q;
  assign bus.err_sel   = err_q;
  assign bus.pending   = count_s;
  assign bus.busy      = (state_q != IDLE) || !empty_s;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed bench for reg_write_sequencer with six target registers so that
// out-of-range selects can be exercised.
module tb_reg_write_sequencer;

  localparam int NR = 6;
  localparam int SW = 3;
  localparam int FD = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_write_sequencer_if #(.NUM_REGS(NR), .SEL_W(SW), .CNT_W(CW)) bus ();

  reg_write_sequencer #(
    .NUM_REGS   (NR),
    .SEL_W      (SW),
    .FIFO_DEPTH (FD),
    .CNT_W      (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int        q_cyc [$];
  logic [5:0] q_lat [$];
  logic [7:0] q_dat [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_cyc.delete();
    q_lat.delete();
    q_dat.delete();
  endtask

  // Strobe logger: records every latch pulse with the data seen alongside it.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if ((|bus.reg_latch) === 1'b1) begin
      q_cyc.push_back(cyc);
      q_lat.push_back(bus.reg_latch);
      q_dat.push_back(bus.reg_data);
      chk("onehot", 32'($countones(bus.reg_latch)), 32'd1);
    end
  end

  initial begin
    bus.req_valid = 1'b1;
    bus.req_sel   = 3'd3;
    bus.req_data  = 8'h77;
    bus.err_clr   = 1'b0;
    rst_n         = 1'b0;

    // Reset held two cycles with a request pending
    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_data", 32'(bus.reg_data), 32'h00);
    chk("rst_latch", 32'(bus.reg_latch), 32'h00);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err_sel), 32'd0);
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.req_ready), 32'd1);

    // Single write sel=3 data=A5, accepted while IDLE and empty
    tick();
    bus.req_valid = 1'b1;
    bus.req_sel   = 3'd3;
    bus.req_data  = 8'hA5;
    tick();  // E0
    bus.req_valid = 1'b0;
    chk("sw_e0_pending", 32'(bus.pending), 32'd1);
    chk("sw_e0_data", 32'(bus.reg_data), 32'h00);
    chk("sw_e0_busy", 32'(bus.busy), 32'd1);
    tick();  // E1
    chk("sw_e1_data", 32'(bus.reg_data), 32'hA5);
    chk("sw_e1_latch", 32'(bus.reg_latch), 32'h00);
    chk("sw_e1_pending", 32'(bus.pending), 32'd0);
    tick();  // E2
    chk("sw_e2_latch", 32'(bus.reg_latch), 32'h08);
    chk("sw_e2_data", 32'(bus.reg_data), 32'hA5);
    tick();  // E3
    chk("sw_e3_latch", 32'(bus.reg_latch), 32'h00);
    chk("sw_e3_data", 32'(bus.reg_data), 32'hA5);
    tick();  // E4
    chk("sw_e4_data", 32'(bus.reg_data), 32'hA5);
    chk("sw_e4_busy", 32'(bus.busy), 32'd0);

    // Burst of six with req_valid held
    clear_log();
    bus.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.req_sel  = SW'(i);
      bus.req_data = 8'(8'h10 + i);
      chk("burst_ready", 32'(bus.req_ready), 32'd1);
      tick();
    end
    bus.req_valid = 1'b0;
    chk("burst_full_pending", 32'(bus.pending), 32'd4);
    chk("burst_full_ready", 32'(bus.req_ready), 32'd0);
    for (int k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      tick();
    end
    chk("burst_drain", 32'(bus.busy), 32'd0);
    chk("burst_count", 32'(q_cyc.size()), 32'd6);
    for (int i = 0; i < 6 && i < q_cyc.size(); i++) begin
      chk($sformatf("burst_latch%0d", i), 32'(q_lat[i]), 32'd1 << i);
      chk($sformatf("burst_data%0d", i), 32'(q_dat[i]), 32'h10 + 32'(i));
      if (i > 0) chk($sformatf("burst_gap%0d", i), 32'(q_cyc[i] - q_cyc[i-1]), 32'd3);
    end

    // Invalid selects: sel=6 is the first out-of-range index
    clear_log();
    bus.req_valid = 1'b1;
    bus.req_sel   = 3'd6;
    bus.req_data  = 8'hEE;
    tick();
    bus.req_valid = 1'b0;
    chk("inv_pending", 32'(bus.pending), 32'd0);
    chk("inv_err", 32'(bus.err_sel), 32'd1);
    chk("inv_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    tick();
    chk("inv_nostrobe", 32'(q_cyc.size()), 32'd0);
    chk("inv_err_sticky", 32'(bus.err_sel), 32'd1);
    bus.err_clr   = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_sel   = 3'd7;
    tick();
    bus.req_valid = 1'b0;
    chk("inv_set_wins", 32'(bus.err_sel), 32'd1);
    chk("inv7_pending", 32'(bus.pending), 32'd0);
    tick();
    bus.err_clr = 1'b0;
    chk("inv_cleared", 32'(bus.err_sel), 32'd0);

    // Reset during STROBE of the second write with three entries queued
    tick();
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req_sel  = SW'(i + 1);
      bus.req_data = 8'(8'h20 + i);
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    chk("mid_latch", 32'(bus.reg_latch), 32'h04);
    chk("mid_data", 32'(bus.reg_data), 32'h21);
    chk("mid_pending", 32'(bus.pending), 32'd3);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_latch", 32'(bus.reg_latch), 32'h00);
    chk("mid_rst_pending", 32'(bus.pending), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_data", 32'(bus.reg_data), 32'h00);
    rst_n = 1'b1;
    clear_log();
    for (int k = 0; k < 10; k++) tick();
    chk("mid_no_strobes", 32'(q_cyc.size()), 32'd0);
    chk("mid_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
